uart_msg_match: RTL and testbench

//   Receive-side counterpart of the UART hello transmitter. Consumes bytes from UART_Rx via valid/ack.

---
 rtl/uart_msg_match.sv | 106 ++++++++++
 tb/tb_uart_msg_match.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_match.sv
// Byte-stream matcher: consumes UART_Rx bytes over valid/ack and pulses match when C_MSG completes.
// Optional build macro MSG_MATCH_NOCASE_EN folds ASCII letters to upper case before comparing.
module uart_msg_match #(
  parameter int unsigned C_UART_DATA_WIDTH = 8,
  parameter int unsigned C_MSG_LEN         = 5,
  parameter int unsigned C_CNT_WIDTH       = 8,
  parameter logic [C_MSG_LEN*C_UART_DATA_WIDTH-1:0] C_MSG = "Hello"
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               clr,
  input  logic                               rxValid,
  output logic                               rxAck,
  input  logic [C_UART_DATA_WIDTH-1:0]       rxData,
  input  logic                               rxErr,
  output logic                               match,
  output logic [C_CNT_WIDTH-1:0]             matchCount,
  output logic [$clog2(C_MSG_LEN+1)-1:0]     progress
);

  localparam int unsigned W  = C_UART_DATA_WIDTH;
  localparam int unsigned PW = $clog2(C_MSG_LEN + 1);
  localparam int unsigned CW = C_CNT_WIDTH;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t           state, state_d;
  logic             ack_d, match_d;
  logic [CW-1:0]    cnt_d;
  logic [PW-1:0]    prog_d;
  logic [W-1:0]     msg_chars [C_MSG_LEN];
  logic             hit_cur, hit_first;

  // Unpack the message so that index 0 is the first character on the wire.
  for (genvar k = 0; k < C_MSG_LEN; k++) begin : g_chars
    assign msg_chars[k] = C_MSG[(C_MSG_LEN-k)*W-1 -: W];
  end

  function automatic logic [W-1:0] fold(input logic [W-1:0] c);
`ifdef MSG_MATCH_NOCASE_EN
    if (W >= 8 && c >= W'(8'h61) && c <= W'(8'h7A)) return c - W'(8'h20);
`endif
    return c;
  endfunction

  assign hit_cur   = (fold(rxData) == fold(msg_chars[progress]));
  assign hit_first = (fold(rxData) == fold(msg_chars[0]));

  // State register plus registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      rxAck      <= 1'b0;
      match      <= 1'b0;
      matchCount <= '0;
      progress   <= '0;
    end else begin
      state      <= state_d;
      rxAck      <= ack_d;
      match      <= match_d;
      matchCount <= cnt_d;
      progress   <= prog_d;
    end
  end

  // Next-state, handshake and match-progress logic.
  always_comb begin
    state_d = state;
    ack_d   = 1'b0;
    match_d = 1'b0;
    cnt_d   = matchCount;
    prog_d  = progress;
    case (state)
      IDLE: begin
        if (rxValid) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (rxErr) begin
            prog_d = '0;
          end else if (hit_cur) begin
            if (progress == PW'(C_MSG_LEN - 1)) begin
              match_d = 1'b1;
              prog_d  = '0;
              if (matchCount != {CW{1'b1}}) cnt_d = matchCount + CW'(1);
            end else begin
              prog_d = progress + PW'(1);
            end
          end else if (hit_first) begin
            prog_d = PW'(1);
          end else begin
            prog_d = '0;
          end
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!rxValid) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // Clear overrides count and progress but leaves the handshake alone.
    if (clr) begin
      cnt_d  = '0;
      prog_d = '0;
    end
  end

endmodule

// File: tb/tb_uart_msg_match.sv
// Directed self-checking bench for uart_msg_match with default "Hello" parameters.
module tb_uart_msg_match;

  logic       clk = 1'b0;
  logic       rstb;
  logic       clr;
  logic       rxValid;
  logic       rxAck;
  logic [7:0] rxData;
  logic       rxErr;
  logic       match;
  logic [7:0] matchCount;
  logic [2:0] progress;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int match_cnt = 0;

  uart_msg_match dut (
    .clk(clk), .rstb(rstb), .clr(clr), .rxValid(rxValid), .rxAck(rxAck),
    .rxData(rxData), .rxErr(rxErr), .match(match), .matchCount(matchCount),
    .progress(progress)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rxAck) ack_cnt++;
    if (match) match_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one byte, hold valid until ack, return match/progress seen with the ack.
  task automatic send(input logic [7:0] b, input logic e, output logic m, output logic [2:0] p);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    rxData  = b;
    rxErr   = e;
    rxValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rxAck) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ack_timeout", 32'(seen), 32'd1);
    m = match;
    p = progress;
    rxValid = 1'b0;
    rxErr   = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic send_str(input string s);
    logic m;
    logic [2:0] p;
    for (int i = 0; i < s.len(); i++) send(s[i], 1'b0, m, p);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic       m;
    logic [2:0] p;
    int         a0, m0;
    string      s2;
    logic [2:0] exp_p2 [7];
    exp_p2 = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    rstb = 1'b0; clr = 1'b0; rxValid = 1'b0; rxData = 8'h00; rxErr = 1'b0;
    #22;
    check("rst_ack", 32'(rxAck), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(matchCount), 32'd0);
    check("rst_progress", 32'(progress), 32'd0);
    rstb = 1'b1;

    // 1: plain Hello
    a0 = ack_cnt; m0 = match_cnt;
    send_str("Hello");
    @(negedge clk);
    check("t1_count", 32'(matchCount), 32'd1);
    check("t1_progress", 32'(progress), 32'd0);
    check("t1_acks", 32'(ack_cnt - a0), 32'd5);
    check("t1_pulses", 32'(match_cnt - m0), 32'd1);

    // 2: restart on first char
    s2 = "HeHello";
    for (int i = 0; i < 7; i++) begin
      send(s2[i], 1'b0, m, p);
      check($sformatf("t2_prog%0d", i), 32'(p), 32'(exp_p2[i]));
      check($sformatf("t2_match%0d", i), 32'(m), (i == 6) ? 32'd1 : 32'd0);
    end
    check("t2_count", 32'(matchCount), 32'd2);

    // 3: errored byte breaks the message
    send_str("Hel");
    check("t3_prog_pre", 32'(progress), 32'd3);
    send(8'h6C, 1'b1, m, p);
    check("t3_prog_err", 32'(p), 32'd0);
    m0 = match_cnt;
    send_str("lo");
    @(negedge clk);
    check("t3_nomatch", 32'(match_cnt - m0), 32'd0);
    check("t3_count", 32'(matchCount), 32'd2);

    // 4: saturation and clear
    pulse_clr();
    check("t4_clr0", 32'(matchCount), 32'd0);
    for (int i = 0; i < 260; i++) begin
      send_str("Hello");
      if (i == 254) check("t4_at255", 32'(matchCount), 32'd255);
    end
    check("t4_sat", 32'(matchCount), 32'd255);
    pulse_clr();
    check("t4_clr", 32'(matchCount), 32'd0);
    check("t4_clr_prog", 32'(progress), 32'd0);

    // 5: valid held for 10 cycles consumes one byte
    a0 = ack_cnt;
    @(negedge clk);
    rxData = 8'h48; rxValid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t5_acks", 32'(ack_cnt - a0), 32'd1);
    check("t5_prog", 32'(progress), 32'd1);
    rxValid = 1'b0;
    repeat (2) @(posedge clk);

    // 6: case sensitivity
    pulse_clr();
    send_str("hELLO");
    @(negedge clk);
`ifdef MSG_MATCH_NOCASE_EN
    check("t6_case", 32'(matchCount), 32'd1);
`else
    check("t6_case", 32'(matchCount), 32'd0);
`endif

    // Async reset mid-handshake, then a still-high valid is consumed again
    pulse_clr();
    send_str("Hel");
    @(negedge clk);
    rxData = 8'h6C; rxValid = 1'b1;
    @(posedge clk); #1;
    check("t7_ack_hi", 32'(rxAck), 32'd1);
    check("t7_prog4", 32'(progress), 32'd4);
    #1 rstb = 1'b0;
    #1;
    check("t7_rst_ack", 32'(rxAck), 32'd0);
    check("t7_rst_prog", 32'(progress), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk); #1;
    check("t7_reack", 32'(rxAck), 32'd1);
    check("t7_reprog", 32'(progress), 32'd0);
    rxValid = 1'b0;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
